// File: rtl/irq_controller_banked.sv
// Banked interrupt controller: NUM_SRC active-low sources in banks of 8, level/edge modes, W1C pending, priority vector.
// Edge pin-to-irq SYNC_STAGES+2 clk, level SYNC_STAGES+1 clk; bus reads are combinational and never stall.
module irq_controller_banked #(
  parameter int NUM_SRC     = 16,
  parameter int SYNC_STAGES = 2,
  parameter int ADDR_W      = 5
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                phi2,
  input  logic                cs_n,
  input  logic                write_enable,
  input  logic [ADDR_W-1:0]   address,
  input  logic [7:0]          data_in,
  output logic [7:0]          data_out,
  input  logic [NUM_SRC-1:0]  irq_sources_n,
  output logic                irq_out_n
);

  localparam int BANK_W = ADDR_W - 3;
  localparam int NB_MAX = 1 << BANK_W;

  logic [NUM_SRC-1:0] sync_q [SYNC_STAGES];
  logic [NUM_SRC-1:0] act, act_q, edge_det;
  logic [NUM_SRC-1:0] enable_q, mode_q, pend_q;
  logic [NUM_SRC-1:0] enable_d, mode_d, pend_d, clr;
  logic [NUM_SRC-1:0] pend_eff, pe;
  logic               phi2_q, wr_stb;
  logic [BANK_W-1:0]  bank;
  logic [2:0]         reg_idx;
  logic [7:0]         stat_b [NB_MAX];
  logic [7:0]         en_b   [NB_MAX];
  logic [7:0]         mode_b [NB_MAX];
  logic [7:0]         raw_b  [NB_MAX];
  logic [7:0]         vector;

  assign bank     = address[ADDR_W-1:3];
  assign reg_idx  = address[2:0];
  assign wr_stb   = phi2_q & ~phi2 & ~cs_n & write_enable;
  assign act      = ~sync_q[SYNC_STAGES-1];
  assign edge_det = act & ~act_q;
  // Level bits track the synchronised input directly; only edge bits are latched.
  assign pend_eff = (mode_q & pend_q) | (~mode_q & act);
  assign pe       = pend_eff & enable_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '1;
      act_q     <= '0;
      enable_q  <= '0;
      mode_q    <= '0;
      pend_q    <= '0;
      phi2_q    <= 1'b0;
      irq_out_n <= 1'b1;
    end else begin
      sync_q[0] <= irq_sources_n;
      for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
      act_q     <= act;
      enable_q  <= enable_d;
      mode_q    <= mode_d;
      pend_q    <= pend_d;
      phi2_q    <= phi2;
      irq_out_n <= ~|pe;
    end
  end

  always_comb begin
    enable_d = enable_q;
    mode_d   = mode_q;
    clr      = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (wr_stb && int'(bank) == i / 8) begin
        case (reg_idx)
          3'd0:    clr[i]      = data_in[i % 8];
          3'd1:    enable_d[i] = data_in[i % 8];
          3'd2:    mode_d[i]   = data_in[i % 8];
          default: ;
        endcase
      end
    end
    // A new edge outranks a same-cycle W1C; a mode change always clears.
    pend_d = ((pend_q & ~clr) | (edge_det & mode_q)) & ~(mode_q ^ mode_d);
  end

  always_comb begin
    for (int b = 0; b < NB_MAX; b++) begin
      stat_b[b] = '0;
      en_b[b]   = '0;
      mode_b[b] = '0;
      raw_b[b]  = '0;
    end
    for (int i = 0; i < NUM_SRC; i++) begin
      stat_b[i / 8][i % 8] = pe[i];
      en_b[i / 8][i % 8]   = enable_q[i];
      mode_b[i / 8][i % 8] = mode_q[i];
      raw_b[i / 8][i % 8]  = act[i];
    end
    vector = 8'h00;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (pe[i]) vector = 8'h80 | 8'(i);
    end
  end

  always_comb begin
    data_out = 8'h00;
    if (!cs_n) begin
      case (reg_idx)
        3'd0:    data_out = stat_b[bank];
        3'd1:    data_out = en_b[bank];
        3'd2:    data_out = mode_b[bank];
        3'd3:    data_out = raw_b[bank];
        3'd4:    data_out = vector;
        default: data_out = 8'h00;
      endcase
    end
  end

endmodule
